// File: rtl/scan_mult_chain.sv
// scan_mult_chain
//   Multi-channel scan-chain test wrapper around a W x W multiplier.
//   Each channel owns a 2*W-bit chain {a, b}. The chain can shift serially
//   (LSB out first), capture the product a*b in parallel, or hold.
//   One shared shift counter reports when a full chain load is complete.
//
//   Build option: define SCAN_SIGNED_EN to treat a and b as two's-complement
//   operands. The default build (macro undefined) multiplies unsigned.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   scan_en      shift enable (priority over capture_en)
//   capture_en   parallel capture of the products (only when scan_en=0)
//   scan_in      serial input, bit c feeds chain c
//   scan_out     registered serial output, bit c comes from chain c
//   shift_cnt    shifts since the last reset or capture, saturates at 2*W
//   chain_loaded high while shift_cnt == 2*W
module scan_mult_chain #(
  parameter int W      = 4,
  parameter int CHAINS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scan_en,
  input  logic                        capture_en,
  input  logic [CHAINS-1:0]           scan_in,
  output logic [CHAINS-1:0]           scan_out,
  output logic [$clog2(2*W+1)-1:0]    shift_cnt,
  output logic                        chain_loaded
);

  localparam int N     = 2 * W;
  localparam int CNT_W = $clog2(N + 1);

  // Full-width product of the two chain halves. Both operands are extended to
  // N bits before multiplying, so the low N bits are the exact product; it
  // never overflows, including the signed corner (-2^(W-1))^2.
  function automatic logic [N-1:0] mult_prod(input logic [N-1:0] v);
`ifdef SCAN_SIGNED_EN
    logic signed [N-1:0] ax;
    logic signed [N-1:0] bx;
    ax = {{W{v[N-1]}}, v[N-1:W]};
    bx = {{W{v[W-1]}}, v[W-1:0]};
`else
    logic [N-1:0] ax;
    logic [N-1:0] bx;
    ax = {{W{1'b0}}, v[N-1:W]};
    bx = {{W{1'b0}}, v[W-1:0]};
`endif
    return N'(ax * bx);
  endfunction

  logic [N-1:0] ch_p0 [CHAINS];
  logic [N-1:0] prod  [CHAINS];

  always_comb begin
    for (int c = 0; c < CHAINS; c++) begin
      prod[c] = mult_prod(ch_p0[c]);
    end
  end

  // Stage p0: chain registers, serial output and the shared shift counter.
  // All channels share control, so a single counter tracks every chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHAINS; c++) begin
        ch_p0[c] <= '0;
      end
      scan_out  <= '0;
      shift_cnt <= '0;
    end else if (scan_en) begin
      for (int c = 0; c < CHAINS; c++) begin
        ch_p0[c]    <= {scan_in[c], ch_p0[c][N-1:1]};
        scan_out[c] <= ch_p0[c][0];
      end
      if (shift_cnt != CNT_W'(N)) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end else if (capture_en) begin
      for (int c = 0; c < CHAINS; c++) begin
        ch_p0[c] <= prod[c];
      end
      shift_cnt <= '0;
    end
  end

  assign chain_loaded = (shift_cnt == CNT_W'(N));

endmodule

// File: tb/tb_scan_mult_chain.sv
// tb_scan_mult_chain
//   Drives two instances side by side with shared control: a W=4, CHAINS=1
//   block and a W=8, CHAINS=3 block. A value-level model tracks each chain as
//   an integer and is compared against scan_out, shift_cnt and chain_loaded
//   after every edge; directed scenarios add checks against known results.
module tb_scan_mult_chain;

  logic       clk = 1'b0;
  logic       rst, scan_en, capture_en;
  logic [0:0] si4, so4;
  logic [3:0] cnt4;
  logic       ld4;
  logic [2:0] si8, so8;
  logic [4:0] cnt8;
  logic       ld8;

  int checks   = 0;
  int failures = 0;

  // model state
  longint m4, m4o, m4c;
  longint m8 [3];
  longint m8o [3];
  longint m8c;

  logic [15:0] g4;
  logic [47:0] g8;

  always #5 clk = ~clk;

  scan_mult_chain #(.W(4), .CHAINS(1)) dut4 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .capture_en(capture_en),
    .scan_in(si4), .scan_out(so4), .shift_cnt(cnt4), .chain_loaded(ld4)
  );

  scan_mult_chain #(.W(8), .CHAINS(3)) dut8 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .capture_en(capture_en),
    .scan_in(si8), .scan_out(so8), .shift_cnt(cnt8), .chain_loaded(ld8)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // product of a w-bit a and b, reduced to 2*w bits
  function automatic longint mprod(input longint a, input longint b, input int w);
    longint half, full;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
`ifdef SCAN_SIGNED_EN
    if (a >= half) a = a - full;
    if (b >= half) b = b - full;
`endif
    return (a * b) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic cyc(input logic r, input logic se, input logic ce,
                     input logic s4, input logic [2:0] s8);
    rst = r; scan_en = se; capture_en = ce; si4[0] = s4; si8 = s8;
    @(posedge clk);
    if (r) begin
      m4 = 0; m4o = 0; m4c = 0; m8c = 0;
      for (int c = 0; c < 3; c++) begin m8[c] = 0; m8o[c] = 0; end
    end else if (se) begin
      m4o = m4 % 2;
      m4  = m4 / 2 + longint'(s4) * 128;
      m4c = (m4c < 8) ? m4c + 1 : 8;
      for (int c = 0; c < 3; c++) begin
        m8o[c] = m8[c] % 2;
        m8[c]  = m8[c] / 2 + longint'(s8[c]) * 32768;
      end
      m8c = (m8c < 16) ? m8c + 1 : 16;
    end else if (ce) begin
      m4 = mprod(m4 / 16, m4 % 16, 4);
      m4c = 0;
      for (int c = 0; c < 3; c++) m8[c] = mprod(m8[c] / 256, m8[c] % 256, 8);
      m8c = 0;
    end
    #1;
    chk("so4", so4, m4o);
    chk("cnt4", cnt4, m4c);
    chk("ld4", ld4, (m4c == 8) ? 1 : 0);
    for (int c = 0; c < 3; c++) chk("so8", so8[c], m8o[c]);
    chk("cnt8", cnt8, m8c);
    chk("ld8", ld8, (m8c == 16) ? 1 : 0);
  endtask

  // n shifts; v4/v8 bit k is fed on shift k, g4/g8 bit k is scan_out after it
  task automatic shift_n(input int n, input logic ce, input logic [15:0] v4,
                         input logic [47:0] v8,
                         output logic [15:0] o4, output logic [47:0] o8);
    o4 = '0; o8 = '0;
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b1, ce, v4[k], {v8[32+k], v8[16+k], v8[k]});
      o4[k] = so4[0];
      o8[k] = so8[0]; o8[16+k] = so8[1]; o8[32+k] = so8[2];
    end
  endtask

  task automatic rnd_v(output logic [15:0] v4, output logic [47:0] v8);
    v4 = 16'($urandom);
    v8 = {16'($urandom), 32'($urandom)};
  endtask

  logic [15:0] r4;
  logic [47:0] r8;
  logic [15:0] exp_ff;

  initial begin
    rst = 1'b1; scan_en = 1'b0; capture_en = 1'b0; si4 = '0; si8 = '0;

    // reset with random scan activity
    cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom), 3'($urandom));
    cyc(1'b1, 1'($urandom), 1'b0, 1'($urandom), 3'($urandom));
    chk("rst_so", so4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_ld", ld4, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    rnd_v(r4, r8);
    shift_n(8, 1'b0, r4, r8, g4, g8);
    chk("rst_cap", g4[7:0], 8'h00);

    // load 0x35, capture 3*5, unload
    rnd_v(r4, r8);
    shift_n(8, 1'b0, 16'h0035, r8, g4, g8);
    chk("loaded", ld4, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    chk("cap_cnt", cnt4, 0);
    rnd_v(r4, r8);
    shift_n(8, 1'b0, r4, r8, g4, g8);
    chk("p35", g4[7:0], 8'h0F);

    // signed vs unsigned operands
    rnd_v(r4, r8);
    shift_n(8, 1'b0, 16'h00D5, r8, g4, g8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    shift_n(8, 1'b0, 16'h0088, r8, g4, g8);
`ifdef SCAN_SIGNED_EN
    chk("pD5", g4[7:0], 8'hF1);
`else
    chk("pD5", g4[7:0], 8'h41);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    rnd_v(r4, r8);
    shift_n(8, 1'b0, r4, r8, g4, g8);
    chk("p88", g4[7:0], 8'h40);

    // hold keeps contents; scan_en wins over capture_en
    shift_n(8, 1'b0, 16'h0035, r8, g4, g8);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 3'($urandom));
    chk("hold_cnt", cnt4, 8);
    rnd_v(r4, r8);
    shift_n(8, 1'b1, r4, r8, g4, g8);
    chk("prio", g4[7:0], 8'h35);

    // multi-chain saturation and capture
    rnd_v(r4, r8);
    shift_n(16, 1'b0, r4, r8, g4, g8);
    shift_n(4, 1'b0, r4, r8, g4, g8);
    chk("sat16", cnt8, 16);
    chk("sat_ld", ld8, 1);
    shift_n(16, 1'b0, r4, {16'h0C0A, 16'h007F, 16'hFFFF}, g4, g8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    rnd_v(r4, r8);
    shift_n(16, 1'b0, r4, r8, g4, g8);
`ifdef SCAN_SIGNED_EN
    exp_ff = 16'h0001;
`else
    exp_ff = 16'hFE01;
`endif
    chk("mc0", g8[15:0], exp_ff);
    chk("mc1", g8[31:16], 16'h0000);
    chk("mc2", g8[47:32], 16'h0078);

    // reset in the middle of a load
    rnd_v(r4, r8);
    shift_n(5, 1'b0, r4, r8, g4, g8);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'b111);
    chk("mid_cnt", cnt4, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    shift_n(8, 1'b0, 16'h0035, r8, g4, g8);
    chk("mid_clr", g4[7:0], 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b0);
    rnd_v(r4, r8);
    shift_n(8, 1'b0, r4, r8, g4, g8);
    chk("mid_p35", g4[7:0], 8'h0F);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
          1'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_mult_chain.md
# scan_mult_chain

Parametrised multi-channel scan-chain test wrapper around a W×W multiplier. It is the next-generation replacement for the fixed 4×4 single-chain scan block. Each channel is a 2·W-bit chain holding operands {a, b}. The chain can be shifted serially, can capture the product a·b in parallel, or can hold. A per-block shift counter tells the tester when a full chain load is complete.

## Interface
Parameters:
- W, default 4: operand width. Chain length N = 2·W; product width = N.
- CHAINS, default 1: number of independent chains/multipliers, all sharing control.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset. Sampled on the rising edge of clk.
- scan_en, input, 1: shift enable. Has priority over capture_en.
- capture_en, input, 1: parallel capture of the products. Effective only when scan_en=0.
- scan_in, input, CHAINS: serial input. Bit c feeds chain c.
- scan_out, output, CHAINS: registered serial output. Bit c comes from chain c.
- shift_cnt, output, $clog2(N+1): shifts since the last reset or capture. Saturates at N.
- chain_loaded, output, 1: high when shift_cnt == N.

## Operation
Per channel c, the chain register is ch[c][N-1:0]:
- Operand a = ch[c][N-1:W] (upper half).
- Operand b = ch[c][W-1:0] (lower half).
- The product p[c] = a·b is combinational, N bits wide, and never truncated.

Mode selection is evaluated each rising edge, in priority order:
- rst=1: ch ← 0, scan_out ← 0, shift_cnt ← 0.
- scan_en=1 (shift):
  - ch[c] ← {scan_in[c], ch[c][N-1:1]}.
  - scan_out[c] ← ch[c][0].
  - shift_cnt ← min(shift_cnt+1, N).
- capture_en=1 (capture):
  - ch[c] ← p[c].
  - scan_out unchanged.
  - shift_cnt ← 0.
- Otherwise (hold): all registers unchanged. The old block captured unconditionally; this one does not.

Loading rules:
- Loading value V takes N shifts, feeding V LSB first. The first bit shifted in ends in ch[0].
- Unloading is LSB first. After shift k (k = 1..N), scan_out shows ch[k-1] as it was before shifting began.
- Load and unload overlap: the next pattern shifts in while the previous result shifts out.
- All channels use the same scan_en and capture_en. Their shift_cnt values are therefore identical, so one counter serves the whole block.

## Timing
- Reset values: scan_out = 0, shift_cnt = 0, chain_loaded = 0, all chains = 0.
- Shift latency: the bit on scan_in at edge t is in ch[N-1] after edge t. It reaches scan_out after edge t+N.
- Capture latency: one edge. The product of the operands present before edge t is in ch after edge t. Its bit 0 appears on scan_out after the next shift edge.
- chain_loaded is combinational from shift_cnt. It rises in the same cycle that shift_cnt reaches N.
- shift_cnt saturates: further shifts keep it at N, and the chain keeps shifting normally.
- Simultaneous scan_en=1 and capture_en=1: a shift is performed and the capture is ignored.
- Reset asserted mid-shift or mid-capture: all state clears at that edge. The partial load is discarded.
- Hold cycles inserted between shifts do not disturb the count or the chain contents.

## Configuration
- SCAN_SIGNED_EN defined: a and b are two's-complement W-bit values. p is their signed N-bit product, which never overflows, including (−2^(W-1))² = 2^(2W-2).
- SCAN_SIGNED_EN undefined: unsigned multiply.
- The setting affects only the product logic. Shift, hold and the counter behave identically in both builds.

## Test plan
Defaults are W=4, CHAINS=1 unless a scenario says otherwise.
- Reset: rst=1 for 2 edges with random scan_in and scan_en → scan_out = 0, shift_cnt = 0, chain_loaded = 0. A following capture gives ch = 8'h00.
- Load and capture: shift in 8'h35 LSB first (1,0,1,0,1,1,0,0) → chain_loaded = 1 after the 8th shift. Capture → ch = 8'h0F (3·5) and shift_cnt = 0. Then 8 shifts → scan_out sequence 1,1,1,1,0,0,0,0.
- Signed mode: load 8'hD5 and capture. Unsigned build → 8'h41 (13·5). SCAN_SIGNED_EN build → 8'hF1 (−15). Also load 8'h88 and capture → unsigned 8'h40, signed 8'h40.
- Hold and priority: load 8'h35, then scan_en=0 and capture_en=0 for 5 edges → ch stays 8'h35. Then scan_en=1 and capture_en=1 together → a shift occurs, not a capture.
- Multi-chain and saturation: W=8, CHAINS=3, 20 shifts → shift_cnt = 16 (saturated). Load 8'hFF·8'hFF, 8'h00·8'h7F, 8'h0C·8'h0A and capture → 16'hFE01, 16'h0000, 16'h0078, each on its own channel.
- Reset mid-load: assert rst after 5 shifts → shift_cnt = 0 and ch = 0. A subsequent full load works normally.
